// File: rtl/data_memory.sv
// Word-addressed data memory for the load/store stage: combinational gated read,
// synchronous store port, asynchronous active-low clear of the whole array.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];

  logic                 in_range;
  logic [IDX_WIDTH-1:0] idx;

  // Full-width compare so out-of-range addresses never alias onto low words
  assign in_range = (address < ADDR_WIDTH'(DEPTH));
  assign idx      = address[IDX_WIDTH-1:0];

  // Store port; reset clears every word and wins over a pending store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[i] <= '0;
      end
    end else if (mem_write && in_range) begin
      memory[idx] <= write_data;
    end
  end

  // Zero-latency load, forced to zero when disabled, in reset or out of range
  always_comb begin
    read_data = '0;
    if (rst_n && mem_read && in_range) begin
      read_data = memory[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: backdoor loads, stores,
// range boundaries and asynchronous reset behaviour.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_vec;
  int n_err;

  data_memory #(
    .DATA_WIDTH(32),
    .DEPTH     (256),
    .ADDR_WIDTH(32)
  ) dm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    // Initial reset pulse
    #1 rst_n = 1'b0;
    #1;
    check("reset_read", read_data, 32'h0);
    check("reset_mem8", dm.memory[8], 32'h0);
    #10 rst_n = 1'b1;

    // Backdoor load, visible without a clock edge
    @(negedge clk);
    dm.memory[8] = 32'h12345678;
    mem_read = 1'b1;
    address  = 32'd8;
    #1 check("backdoor_read", read_data, 32'h12345678);
    mem_read = 1'b0;
    #1 check("read_disabled", read_data, 32'h0);

    // Store then load, same address, read enabled throughout
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    address    = 32'd3;
    write_data = 32'hDEADBEEF;
    #1 check("pre_store_old", read_data, 32'h0);
    @(posedge clk);
    #1 check("post_store_new", read_data, 32'hDEADBEEF);
    mem_write = 1'b0;
    @(negedge clk);
    check("load_after_store", read_data, 32'hDEADBEEF);

    // Top in-range word
    mem_write  = 1'b1;
    address    = 32'd255;
    write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("store_255", read_data, 32'hCAFEF00D);

    // Out of range reads and writes
    @(negedge clk);
    address = 32'd256;
    #1 check("read_256", read_data, 32'h0);
    address = 32'd300;
    #1 check("read_300", read_data, 32'h0);
    dm.memory[44] = 32'h44444444;
    mem_write  = 1'b1;
    write_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("no_alias_mem44", dm.memory[44], 32'h44444444);
    address = 32'h8000_0008;
    #1 check("read_hi_bits", read_data, 32'h0);
    mem_write  = 1'b1;
    write_data = 32'h0BADF00D;
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("no_alias_mem8", dm.memory[8], 32'h12345678);
    address = 32'd44;
    #1 check("read_44", read_data, 32'h44444444);

    // Reset pulse between edges clears array and output immediately
    @(negedge clk);
    address = 32'd8;
    #1 check("pre_reset_read8", read_data, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check("reset_mem8_clr", dm.memory[8], 32'h0);
    check("reset_mem3_clr", dm.memory[3], 32'h0);
    check("reset_read_zero", read_data, 32'h0);
    rst_n = 1'b1;
    #1 check("post_reset_read8", read_data, 32'h0);

    // Store attempted while reset held across an edge
    @(negedge clk);
    rst_n      = 1'b0;
    mem_write  = 1'b1;
    address    = 32'd5;
    write_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1 check("write_in_reset", dm.memory[5], 32'h0);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n     = 1'b1;
    #1 check("read5_after_reset", read_data, 32'h0);

    // Unknown write enable must not store
    mem_write  = 1'bx;
    address    = 32'd6;
    write_data = 32'h00000001;
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("x_enable_no_write", dm.memory[6], 32'h0);

    // Write with read disabled, then enable read
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = 32'd7;
    write_data = 32'h13579BDF;
    @(posedge clk);
    #1 mem_write = 1'b0;
    check("write_noread_out", read_data, 32'h0);
    mem_read = 1'b1;
    #1 check("write_noread_mem", read_data, 32'h13579BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
